// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin bus arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_TIMEOUT
    } arb_state_e;

    localparam int STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin selector: first set request after last_idx_i, wrapping.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_idx_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] cand;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand     = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last_idx_i) + k) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o        = 1'b1;
                idx_o          = cand;
                onehot_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Registered round-robin Wishbone arbiter with lock, preemption and strobe watchdog.
// Define WB_ARB_STATS_EN to add saturating grant/timeout statistics counters.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTER       = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_MASTER-1:0]         cyc_i,
    input  logic [N_MASTER-1:0]         stb_i,
    input  logic [N_MASTER-1:0]         lock_i,
    input  logic                        ack_i,
    input  logic                        err_i,
    input  logic                        rty_i,
    output logic [N_MASTER-1:0]         gnt_o,
    output logic [$clog2(N_MASTER)-1:0] gnt_idx_o,
    output logic                        gnt_valid_o,
    output logic                        to_err_o
`ifdef WB_ARB_STATS_EN
    ,
    input  logic                                stat_clr_i,
    output logic [N_MASTER-1:0][STAT_W-1:0]     stat_gnt_o,
    output logic [STAT_W-1:0]                   stat_to_o
`endif
);

    localparam int IW = $clog2(N_MASTER);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e          state_q, state_d;
    logic [N_MASTER-1:0] gnt_q, gnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [IW-1:0]       last_q, last_d;
    logic [TW-1:0]       timer_q, timer_d;

    logic [N_MASTER-1:0] req;
    logic [N_MASTER-1:0] pick_oh;
    logic [IW-1:0]       pick_idx;
    logic                pick_vld;
    logic                term;
    logic                owner_cyc;
    logic                owner_stb;
    logic                owner_lock;
    logic                take;
    logic                drop;

    // The current owner never competes: on release its cyc is already low,
    // on preempt and timeout it must be skipped.
    assign req        = cyc_i & ~gnt_q;
    assign term       = ack_i | err_i | rty_i;
    assign owner_cyc  = |(cyc_i & gnt_q);
    assign owner_stb  = |(stb_i & gnt_q);
    assign owner_lock = |(lock_i & gnt_q);

    wb_rr_pick #(
        .N  (N_MASTER),
        .IW (IW)
    ) u_pick (
        .req_i      (req),
        .last_idx_i (last_q),
        .onehot_o   (pick_oh),
        .idx_o      (pick_idx),
        .valid_o    (pick_vld)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        timer_d = timer_q;
        take    = 1'b0;
        drop    = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                timer_d = '0;
                take    = pick_vld;
            end
            ARB_GRANT: begin
                if (!owner_cyc) begin
                    timer_d = '0;
                    take    = pick_vld;
                    drop    = !pick_vld;
                end else if (term && !owner_lock && pick_vld) begin
                    timer_d = '0;
                    take    = 1'b1;
                end else if (term) begin
                    timer_d = '0;
                end else if (owner_stb) begin
                    if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        timer_d = '0;
                        state_d = ARB_TIMEOUT;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end else begin
                    timer_d = '0;
                end
            end
            ARB_TIMEOUT: begin
                timer_d = '0;
                take    = pick_vld;
                drop    = !pick_vld;
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                timer_d = '0;
            end
        endcase

        if (take) begin
            gnt_d   = pick_oh;
            idx_d   = pick_idx;
            last_d  = pick_idx;
            state_d = ARB_GRANT;
        end else if (drop) begin
            gnt_d   = '0;
            state_d = ARB_IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= IW'(N_MASTER - 1);
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            timer_q <= timer_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = idx_q;
    assign gnt_valid_o = |gnt_q;
    assign to_err_o    = (state_q == ARB_TIMEOUT);

`ifdef WB_ARB_STATS_EN
    logic [N_MASTER-1:0][STAT_W-1:0] stat_gnt_q;
    logic [STAT_W-1:0]               stat_to_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_gnt_q <= '0;
            stat_to_q  <= '0;
        end else if (stat_clr_i) begin
            stat_gnt_q <= '0;
            stat_to_q  <= '0;
        end else begin
            if (take) begin
                stat_gnt_q[pick_idx] <= sat_inc(stat_gnt_q[pick_idx]);
            end
            if (state_q == ARB_TIMEOUT) begin
                stat_to_q <= sat_inc(stat_to_q);
            end
        end
    end

    assign stat_gnt_o = stat_gnt_q;
    assign stat_to_o  = stat_to_q;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: ownership model plus directed scenarios.
module tb_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [N-1:0]         cyc_i  = '0;
    logic [N-1:0]         stb_i  = '0;
    logic [N-1:0]         lock_i = '0;
    logic                 ack_i  = 1'b0;
    logic                 err_i  = 1'b0;
    logic                 rty_i  = 1'b0;
    logic [N-1:0]         gnt_o;
    logic [$clog2(N)-1:0] gnt_idx_o;
    logic                 gnt_valid_o;
    logic                 to_err_o;

`ifdef WB_ARB_STATS_EN
    logic                 stat_clr = 1'b0;
    logic [N-1:0][15:0]   stat_gnt;
    logic [15:0]          stat_to;
`endif

    int checks   = 0;
    int failures = 0;

    // Model state: who owns the bus, who won last, how long the owner has waited.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_wait  = 0;
    bit m_to    = 1'b0;

    logic [N-1:0] seq [5];

    wb_rr_arbiter #(
        .N_MASTER       (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cyc_i       (cyc_i),
        .stb_i       (stb_i),
        .lock_i      (lock_i),
        .ack_i       (ack_i),
        .err_i       (err_i),
        .rty_i       (rty_i),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o),
        .gnt_valid_o (gnt_valid_o),
        .to_err_o    (to_err_o)
`ifdef WB_ARB_STATS_EN
        ,
        .stat_clr_i  (stat_clr),
        .stat_gnt_o  (stat_gnt),
        .stat_to_o   (stat_to)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int rr(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic hand_to(input int w);
        if (w >= 0) begin
            m_owner = w;
            m_last  = w;
        end else begin
            m_owner = -1;
        end
        m_wait = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] others;
        bit           term;
        term   = ack_i | err_i | rty_i;
        others = cyc_i;
        if (m_owner >= 0) others[m_owner] = 1'b0;
        if (m_to) begin
            m_to = 1'b0;
            hand_to(rr(others, m_last));
        end else if (m_owner < 0 || !cyc_i[m_owner]) begin
            hand_to(rr(others, m_last));
        end else if (term) begin
            m_wait = 0;
            if (!lock_i[m_owner] && others != '0) hand_to(rr(others, m_last));
        end else if (stb_i[m_owner]) begin
            m_wait++;
            if (m_wait == TO) begin
                m_to   = 1'b1;
                m_wait = 0;
            end
        end else begin
            m_wait = 0;
        end
    endtask

    initial forever begin
        @(posedge clk_i or posedge rst_i);
        if (rst_i) begin
            m_owner = -1;
            m_last  = N - 1;
            m_wait  = 0;
            m_to    = 1'b0;
        end else begin
            model_step();
        end
    end

    initial forever begin
        @(negedge clk_i);
        chk("model_gnt", gnt_o, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("model_valid", gnt_valid_o, (m_owner >= 0) ? 32'd1 : 32'd0);
        chk("model_to_err", to_err_o, m_to ? 32'd1 : 32'd0);
        if (m_owner >= 0) chk("model_idx", gnt_idx_o, m_owner);
    end

    task automatic do_reset();
        @(negedge clk_i);
        #2;
        rst_i  = 1'b1;
        cyc_i  = '0;
        stb_i  = '0;
        lock_i = '0;
        ack_i  = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;
    endtask

    initial begin
        seq[0] = 4'b0001;
        seq[1] = 4'b0010;
        seq[2] = 4'b0100;
        seq[3] = 4'b1000;
        seq[4] = 4'b0001;

        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        chk("rst_gnt", gnt_o, 0);
        chk("rst_idx", gnt_idx_o, 0);
        chk("rst_valid", gnt_valid_o, 0);
        chk("rst_to_err", to_err_o, 0);

        // Single master request and release
        @(negedge clk_i);
        cyc_i = 4'b0001;
        @(negedge clk_i);
        chk("s1_gnt", gnt_o, 4'b0001);
        chk("s1_idx", gnt_idx_o, 0);
        chk("s1_valid", gnt_valid_o, 1);
        cyc_i = 4'b0000;
        @(negedge clk_i);
        chk("s1_release", gnt_o, 0);
        chk("s1_release_valid", gnt_valid_o, 0);

        // Fair rotation among four unlocked masters
        do_reset();
        @(negedge clk_i);
        cyc_i = 4'b1111;
        stb_i = 4'b1111;
        ack_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("s2_rotation", gnt_o, seq[i]);
            ack_i = 1'b0;
            @(negedge clk_i);
            chk("s2_no_bubble", gnt_valid_o, 1);
            ack_i = 1'b1;
        end
        @(negedge clk_i);
        cyc_i = '0;
        stb_i = '0;
        ack_i = 1'b0;

        // Locked owner survives acks while another master waits
        do_reset();
        @(negedge clk_i);
        cyc_i  = 4'b0010;
        stb_i  = 4'b0010;
        lock_i = 4'b0010;
        @(negedge clk_i);
        chk("s3_gnt", gnt_o, 4'b0010);
        cyc_i = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            ack_i = 1'b1;
            @(negedge clk_i);
            ack_i = 1'b0;
            chk("s3_lock_hold", gnt_o, 4'b0010);
        end
        cyc_i  = 4'b0100;
        stb_i  = 4'b0000;
        lock_i = 4'b0000;
        @(negedge clk_i);
        chk("s3_next", gnt_o, 4'b0100);

        // Watchdog on an unterminated strobe hands the bus to master 3
        cyc_i = 4'b1100;
        stb_i = 4'b0100;
        for (int i = 0; i < TO - 1; i++) begin
            @(negedge clk_i);
            chk("s4_wait", to_err_o, 0);
        end
        @(negedge clk_i);
        chk("s4_to_err", to_err_o, 1);
        chk("s4_gnt_held", gnt_o, 4'b0100);
        @(negedge clk_i);
        chk("s4_to_err_end", to_err_o, 0);
        chk("s4_gnt_new", gnt_o, 4'b1000);

        // Termination in the threshold cycle beats the watchdog and clears it
        cyc_i = 4'b1000;
        stb_i = 4'b1000;
        for (int i = 0; i < TO - 1; i++) begin
            @(negedge clk_i);
            chk("s5_wait", to_err_o, 0);
        end
        ack_i = 1'b1;
        @(negedge clk_i);
        chk("s5_term_wins", to_err_o, 0);
        ack_i = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            @(negedge clk_i);
            chk("s5_rewait", to_err_o, 0);
        end
        @(negedge clk_i);
        chk("s5_fire", to_err_o, 1);
        chk("s5_fire_gnt", gnt_o, 4'b1000);
        @(negedge clk_i);
        chk("s5_idle", gnt_o, 0);
        chk("s5_idle_valid", gnt_valid_o, 0);
        cyc_i = '0;
        stb_i = '0;

        // Asynchronous reset mid-grant, then fresh arbitration from master 0
        do_reset();
        @(negedge clk_i);
        cyc_i = 4'b0100;
        @(negedge clk_i);
        chk("s6_pre", gnt_o, 4'b0100);
        #2;
        rst_i = 1'b1;
        #1;
        chk("s6_async_gnt", gnt_o, 0);
        chk("s6_async_valid", gnt_valid_o, 0);
        cyc_i = 4'b0101;
        @(negedge clk_i);
        @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("s6_first", gnt_o, 4'b0001);
        chk("s6_first_idx", gnt_idx_o, 0);
        cyc_i = 4'b0100;
        @(negedge clk_i);
        chk("s6_second", gnt_o, 4'b0100);
        chk("s6_second_idx", gnt_idx_o, 2);
        cyc_i = '0;
        @(negedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
